// File: rtl/ibex_trace_pkg.sv
// Shared types for the RVFI trace packer: sync byte, serialiser states and
// the per-instruction record held in the trace FIFO.
// Build option: IBEX_TRACE_MEM_EN adds the memory address/mask words.
package ibex_trace_pkg;

    localparam logic [7:0] TRACE_SYNC = 8'hA5;

    typedef enum logic [2:0] {
        HDR   = 3'd0,
        DROP  = 3'd1,
        PC    = 3'd2,
        INSN  = 3'd3,
        WDATA = 3'd4
`ifdef IBEX_TRACE_MEM_EN
        ,
        MADDR = 3'd5,
        MMASK = 3'd6
`endif
    } trace_state_e;

    typedef struct packed {
        logic        trap;
        logic        intr;
        logic        halt;
        logic        ovf;
        logic [1:0]  mode;
        logic [4:0]  rd_addr;
        logic [11:0] order;
        logic [15:0] drop_cnt;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] wdata;
`ifdef IBEX_TRACE_MEM_EN
        logic [31:0] mem_addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
`endif
    } trace_rec_t;

endpackage

// File: rtl/ibex_rvfi_trace_fifo.sv
// Synchronous record FIFO for the trace packer. A push while full is
// ignored (the caller counts it as a drop); the level comes from the
// registered occupancy count.
// Build option: IBEX_TRACE_MEM_EN widens the stored record.
module ibex_rvfi_trace_fifo
    import ibex_trace_pkg::*;
#(
    parameter int unsigned Depth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  trace_rec_t               wdata_i,
    input  logic                     pop_i,
    output trace_rec_t               rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   level_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);
    localparam logic [PtrW:0]   CntOne   = (PtrW+1)'(1);
    localparam logic [PtrW:0]   CntDepth = (PtrW+1)'(Depth);

    trace_rec_t      mem_r [Depth];
    logic [PtrW-1:0] wr_ptr_r;
    logic [PtrW-1:0] rd_ptr_r;
    logic [PtrW:0]   count_r;
    logic            push_en_s;
    logic            pop_en_s;

    assign full_o    = (count_r == CntDepth);
    assign empty_o   = (count_r == '0);
    assign push_en_s = push_i && !full_o;
    assign pop_en_s  = pop_i && !empty_o;
    assign rdata_o   = mem_r[rd_ptr_r];
    assign level_o   = count_r;

    // Record storage; contents need no reset because the count gates reads.
    always_ff @(posedge clk_i) begin
        if (push_en_s) begin
            mem_r[wr_ptr_r] <= wdata_i;
        end
    end

    // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_en_s) begin
                wr_ptr_r <= wr_ptr_r + PtrOne;
            end
            if (pop_en_s) begin
                rd_ptr_r <= rd_ptr_r + PtrOne;
            end
            case ({push_en_s, pop_en_s})
                2'b10:   count_r <= count_r + CntOne;
                2'b01:   count_r <= count_r - CntOne;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ibex_rvfi_trace_packer.sv
// Captures one record per retired instruction from RVFI and serialises it
// as a stream of 32-bit words (header, optional drop count, PC, instruction,
// rd write data, optional memory address and masks) over valid/ready.
// Build option: IBEX_TRACE_MEM_EN enables the memory address/mask words.
module ibex_rvfi_trace_packer
    import ibex_trace_pkg::*;
#(
    parameter int unsigned Depth = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   trace_en_i,
    input  logic                   rvfi_valid,
    input  logic [63:0]            rvfi_order,
    input  logic [31:0]            rvfi_insn,
    input  logic                   rvfi_trap,
    input  logic                   rvfi_intr,
    input  logic                   rvfi_halt,
    input  logic [1:0]             rvfi_mode,
    input  logic [4:0]             rvfi_rd_addr,
    input  logic [31:0]            rvfi_rd_wdata,
    input  logic [31:0]            rvfi_pc_rdata,
    input  logic [31:0]            rvfi_mem_addr,
    input  logic [3:0]             rvfi_mem_rmask,
    input  logic [3:0]             rvfi_mem_wmask,
    output logic                   trace_valid_o,
    input  logic                   trace_ready_i,
    output logic [31:0]            trace_data_o,
    output logic                   trace_last_o,
    output logic [$clog2(Depth):0] fifo_level_o
);

    trace_state_e state_r;
    trace_rec_t   rec_in_s;
    trace_rec_t   head_s;
    logic [15:0]  drop_cnt_r;
    logic         push_req_s;
    logic         full_s;
    logic         empty_s;
    logic         accept_s;
    logic         pop_s;
    logic         mem_s;
    logic         last_s;
    logic [31:0]  word_s;
    logic         unused_s;

    assign push_req_s = rvfi_valid && trace_en_i;
    assign accept_s   = trace_valid_o && trace_ready_i;
    assign pop_s      = accept_s && last_s;

`ifdef IBEX_TRACE_MEM_EN
    assign mem_s    = ((head_s.rmask | head_s.wmask) != 4'h0);
    assign unused_s = ^rvfi_order[63:12];
`else
    assign mem_s    = 1'b0;
    assign unused_s = ^{rvfi_order[63:12], rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask};
`endif

    // Assemble the incoming record, snapshotting the pending drop count.
    always_comb begin
        rec_in_s          = '0;
        rec_in_s.trap     = rvfi_trap;
        rec_in_s.intr     = rvfi_intr;
        rec_in_s.halt     = rvfi_halt;
        rec_in_s.ovf      = (drop_cnt_r != 16'h0);
        rec_in_s.mode     = rvfi_mode;
        rec_in_s.rd_addr  = rvfi_rd_addr;
        rec_in_s.order    = rvfi_order[11:0];
        rec_in_s.drop_cnt = drop_cnt_r;
        rec_in_s.pc       = rvfi_pc_rdata;
        rec_in_s.insn     = rvfi_insn;
        rec_in_s.wdata    = rvfi_rd_wdata;
`ifdef IBEX_TRACE_MEM_EN
        rec_in_s.mem_addr = rvfi_mem_addr;
        rec_in_s.rmask    = rvfi_mem_rmask;
        rec_in_s.wmask    = rvfi_mem_wmask;
`endif
    end

    ibex_rvfi_trace_fifo #(
        .Depth (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_req_s),
        .wdata_i (rec_in_s),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .level_o (fifo_level_o)
    );

    // Drop counter: saturating count of records lost to a full FIFO, cleared
    // once a written record has carried it out.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_r <= 16'h0;
        end else if (push_req_s && full_s) begin
            if (drop_cnt_r != 16'hFFFF) begin
                drop_cnt_r <= drop_cnt_r + 16'h1;
            end
        end else if (push_req_s) begin
            drop_cnt_r <= 16'h0;
        end
    end

    // Serialiser FSM: walks the words of the head record, one per handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= HDR;
        end else if (accept_s) begin
            case (state_r)
                HDR:     state_r <= head_s.ovf ? DROP : PC;
                DROP:    state_r <= PC;
                PC:      state_r <= INSN;
                INSN:    state_r <= WDATA;
`ifdef IBEX_TRACE_MEM_EN
                WDATA:   state_r <= mem_s ? MADDR : HDR;
                MADDR:   state_r <= MMASK;
                MMASK:   state_r <= HDR;
`else
                WDATA:   state_r <= HDR;
`endif
                default: state_r <= HDR;
            endcase
        end
    end

    // Word mux: select the field of the head record for the current state.
    always_comb begin
        word_s = 32'h0;
        last_s = 1'b0;
        case (state_r)
            HDR: begin
                word_s = {TRACE_SYNC, head_s.trap, head_s.intr, head_s.halt, mem_s,
                          head_s.ovf, head_s.mode, head_s.rd_addr, head_s.order};
            end
            DROP:  word_s = {16'h0, head_s.drop_cnt};
            PC:    word_s = head_s.pc;
            INSN:  word_s = head_s.insn;
            WDATA: begin
                word_s = head_s.wdata;
                last_s = !mem_s;
            end
`ifdef IBEX_TRACE_MEM_EN
            MADDR: word_s = head_s.mem_addr;
            MMASK: begin
                word_s = {head_s.rmask, head_s.wmask, 24'h0};
                last_s = 1'b1;
            end
`endif
            default: begin
                word_s = 32'h0;
                last_s = 1'b0;
            end
        endcase
    end

    assign trace_valid_o = !empty_s;
    assign trace_data_o  = trace_valid_o ? word_s : 32'h0;
    assign trace_last_o  = trace_valid_o && last_s;

endmodule

// File: tb/tb_ibex_rvfi_trace_packer.sv
// Directed bench for ibex_rvfi_trace_packer (Depth = 8). Covers the store
// record differently depending on IBEX_TRACE_MEM_EN.
module tb_ibex_rvfi_trace_packer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        trace_en_i;
    logic        rvfi_valid;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn;
    logic        rvfi_trap, rvfi_intr, rvfi_halt;
    logic [1:0]  rvfi_mode;
    logic [4:0]  rvfi_rd_addr;
    logic [31:0] rvfi_rd_wdata, rvfi_pc_rdata, rvfi_mem_addr;
    logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;
    logic        trace_valid_o, trace_ready_i, trace_last_o;
    logic [31:0] trace_data_o;
    logic [3:0]  fifo_level_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] exp_w [12];
    int          idx, budget;
    logic        prev_hold;
    logic [31:0] prev_d;
    logic        prev_l;

    always #5 clk_i = ~clk_i;

    ibex_rvfi_trace_packer #(.Depth(8)) dut (
        .clk_i (clk_i), .rst_i (rst_i), .trace_en_i (trace_en_i),
        .rvfi_valid (rvfi_valid), .rvfi_order (rvfi_order), .rvfi_insn (rvfi_insn),
        .rvfi_trap (rvfi_trap), .rvfi_intr (rvfi_intr), .rvfi_halt (rvfi_halt),
        .rvfi_mode (rvfi_mode), .rvfi_rd_addr (rvfi_rd_addr), .rvfi_rd_wdata (rvfi_rd_wdata),
        .rvfi_pc_rdata (rvfi_pc_rdata), .rvfi_mem_addr (rvfi_mem_addr),
        .rvfi_mem_rmask (rvfi_mem_rmask), .rvfi_mem_wmask (rvfi_mem_wmask),
        .trace_valid_o (trace_valid_o), .trace_ready_i (trace_ready_i),
        .trace_data_o (trace_data_o), .trace_last_o (trace_last_o),
        .fifo_level_o (fifo_level_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Present one record for a single cycle; returns at the next negedge.
    task automatic send_rec(input logic [11:0] order, input logic [1:0] mode,
                            input logic [4:0] rd, input logic [31:0] pc,
                            input logic [31:0] insn, input logic [31:0] wdata,
                            input logic [31:0] maddr, input logic [3:0] rm,
                            input logic [3:0] wm);
        rvfi_valid     = 1'b1;
        rvfi_order     = {52'h0, order};
        rvfi_mode      = mode;
        rvfi_rd_addr   = rd;
        rvfi_pc_rdata  = pc;
        rvfi_insn      = insn;
        rvfi_rd_wdata  = wdata;
        rvfi_mem_addr  = maddr;
        rvfi_mem_rmask = rm;
        rvfi_mem_wmask = wm;
        @(negedge clk_i);
        rvfi_valid     = 1'b0;
    endtask

    // With ready held high, check the current word and let it be accepted.
    task automatic expect_word(input string tag, input logic [31:0] exp_d, input logic exp_l);
        int n = 0;
        while (!trace_valid_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, "_valid"}, {31'h0, trace_valid_o}, 32'h1);
        check({tag, "_data"}, trace_data_o, exp_d);
        check({tag, "_last"}, {31'h0, trace_last_o}, {31'h0, exp_l});
        @(negedge clk_i);
    endtask

    // Drain plain (mode 0, rd 0, no ovf) records with consecutive orders.
    task automatic drain(input string tag, input int first_order, input int nrec);
        int words = 0;
        int lasts = 0;
        int n = 0;
        trace_ready_i = 1'b1;
        while (trace_valid_o && n < 200) begin
            if (words % 4 == 0) begin
                check({tag, "_hdr"}, trace_data_o, 32'hA500_0000 | 32'(first_order + words / 4));
            end
            words++;
            if (trace_last_o) lasts++;
            @(negedge clk_i);
            n++;
        end
        check({tag, "_words"}, 32'(words), 32'(nrec * 4));
        check({tag, "_lasts"}, 32'(lasts), 32'(nrec));
        check({tag, "_level"}, {28'h0, fifo_level_o}, 32'h0);
    endtask

    initial begin
        rst_i = 1'b1; trace_en_i = 1'b1; trace_ready_i = 1'b1;
        rvfi_valid = 1'b0; rvfi_order = 64'h0; rvfi_insn = 32'h0;
        rvfi_trap = 1'b0; rvfi_intr = 1'b0; rvfi_halt = 1'b0; rvfi_mode = 2'd0;
        rvfi_rd_addr = 5'd0; rvfi_rd_wdata = 32'h0; rvfi_pc_rdata = 32'h0;
        rvfi_mem_addr = 32'h0; rvfi_mem_rmask = 4'h0; rvfi_mem_wmask = 4'h0;

        // Reset
        repeat (2) @(negedge clk_i);
        check("rst_valid", {31'h0, trace_valid_o}, 32'h0);
        check("rst_data", trace_data_o, 32'h0);
        check("rst_last", {31'h0, trace_last_o}, 32'h0);
        check("rst_level", {28'h0, fifo_level_o}, 32'h0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // ALU record, header one cycle after capture
        send_rec(12'd3, 2'd3, 5'd1, 32'h80, 32'h0050_0093, 32'h5, 32'h0, 4'h0, 4'h0);
        check("alu_latency", {31'h0, trace_valid_o}, 32'h1);
        expect_word("alu_h", 32'hA506_1003, 1'b0);
        expect_word("alu_pc", 32'h0000_0080, 1'b0);
        expect_word("alu_in", 32'h0050_0093, 1'b0);
        expect_word("alu_wd", 32'h0000_0005, 1'b1);
        check("alu_level", {28'h0, fifo_level_o}, 32'h0);

        // Capture disabled: record ignored
        trace_en_i = 1'b0;
        send_rec(12'd9, 2'd0, 5'd0, 32'h90, 32'h13, 32'h0, 32'h0, 4'h0, 4'h0);
        check("en_off_valid", {31'h0, trace_valid_o}, 32'h0);
        trace_en_i = 1'b1;

        // Store record
        send_rec(12'd4, 2'd3, 5'd0, 32'h84, 32'h0011_2023, 32'h0, 32'h1000, 4'h0, 4'hF);
`ifdef IBEX_TRACE_MEM_EN
        expect_word("st_h", 32'hA516_0004, 1'b0);
        expect_word("st_pc", 32'h0000_0084, 1'b0);
        expect_word("st_in", 32'h0011_2023, 1'b0);
        expect_word("st_wd", 32'h0000_0000, 1'b0);
        expect_word("st_ma", 32'h0000_1000, 1'b0);
        expect_word("st_mm", 32'h0F00_0000, 1'b1);
`else
        expect_word("st_h", 32'hA506_0004, 1'b0);
        expect_word("st_pc", 32'h0000_0084, 1'b0);
        expect_word("st_in", 32'h0011_2023, 1'b0);
        expect_word("st_wd", 32'h0000_0000, 1'b1);
`endif
        check("st_level", {28'h0, fifo_level_o}, 32'h0);

        // Overflow: 10 records into 8 entries, 2 dropped
        trace_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send_rec(12'(i), 2'd0, 5'd0, 32'h100 + 32'(i), 32'(i), 32'h0, 32'h0, 4'h0, 4'h0);
        end
        check("ovf_level", {28'h0, fifo_level_o}, 32'h8);
        drain("ovf_drain", 0, 8);
        rvfi_trap = 1'b1;
        send_rec(12'h123, 2'd0, 5'd2, 32'h200, 32'h13, 32'h77, 32'h0, 4'h0, 4'h0);
        rvfi_trap = 1'b0;
        expect_word("ovf_h", 32'hA588_2123, 1'b0);
        expect_word("ovf_d", 32'h0000_0002, 1'b0);
        expect_word("ovf_pc", 32'h0000_0200, 1'b0);
        expect_word("ovf_in", 32'h0000_0013, 1'b0);
        expect_word("ovf_wd", 32'h0000_0077, 1'b1);

        // Full with a pop in the same cycle still drops the push
        trace_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_rec(12'h10 + 12'(i), 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0);
        end
        check("fp_full_level", {28'h0, fifo_level_o}, 32'h8);
        trace_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_rec(12'h20 + 12'(i), 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0);
        end
        check("fp_level", {28'h0, fifo_level_o}, 32'h7);
        drain("fp_drain", 16'h11, 7);
        send_rec(12'h5, 2'd0, 5'd0, 32'h44, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0);
        expect_word("fp_h", 32'hA508_0005, 1'b0);
        expect_word("fp_d", 32'h0000_0004, 1'b0);
        expect_word("fp_pc", 32'h0000_0044, 1'b0);
        expect_word("fp_in", 32'h0000_0000, 1'b0);
        expect_word("fp_wd", 32'h0000_0000, 1'b1);

        // Backpressure: random ready across 3 records
        for (int k = 0; k < 3; k++) begin
            exp_w[4*k]   = 32'hA504_4030 + 32'(k);
            exp_w[4*k+1] = 32'h400 + 32'(k);
            exp_w[4*k+2] = 32'h1000 + 32'(k);
            exp_w[4*k+3] = 32'hABC0 + 32'(k);
        end
        trace_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send_rec(12'h30 + 12'(k), 2'd2, 5'd4, 32'h400 + 32'(k), 32'h1000 + 32'(k),
                     32'hABC0 + 32'(k), 32'h0, 4'h0, 4'h0);
        end
        idx = 0; budget = 0; prev_hold = 1'b0; prev_d = 32'h0; prev_l = 1'b0;
        while (idx < 12 && budget < 300) begin
            if (prev_hold) begin
                check("bp_stable_data", trace_data_o, prev_d);
                check("bp_stable_last", {31'h0, trace_last_o}, {31'h0, prev_l});
            end
            trace_ready_i = 1'($urandom_range(0, 1));
            if (trace_valid_o && trace_ready_i) begin
                check("bp_word", trace_data_o, exp_w[idx]);
                check("bp_last", {31'h0, trace_last_o}, (idx % 4 == 3) ? 32'h1 : 32'h0);
                idx++;
            end
            prev_hold = trace_valid_o && !trace_ready_i;
            prev_d    = trace_data_o;
            prev_l    = trace_last_o;
            @(negedge clk_i);
            budget++;
        end
        check("bp_count", 32'(idx), 32'd12);
        check("bp_level", {28'h0, fifo_level_o}, 32'h0);
        trace_ready_i = 1'b1;

        // Reset mid-record with records queued and drops pending
        trace_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send_rec(12'h60 + 12'(i), 2'd0, 5'd0, 32'h600 + 32'(i), 32'h0, 32'h0, 32'h0, 4'h0, 4'h0);
        end
        trace_ready_i = 1'b1;
        @(negedge clk_i);
        check("mr_word2", trace_data_o, 32'h0000_0600);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("mr_valid", {31'h0, trace_valid_o}, 32'h0);
        check("mr_level", {28'h0, fifo_level_o}, 32'h0);
        rst_i = 1'b0;
        send_rec(12'h55, 2'd1, 5'd3, 32'h300, 32'h33, 32'h3, 32'h0, 4'h0, 4'h0);
        expect_word("mr_h", 32'hA502_3055, 1'b0);
        expect_word("mr_pc", 32'h0000_0300, 1'b0);
        expect_word("mr_in", 32'h0000_0033, 1'b0);
        expect_word("mr_wd", 32'h0000_0003, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
